// File: rtl/sig_pkg.sv
// sig_pkg: shared types and constants for the signature record parser and
// the downstream pattern matcher.
package sig_pkg;

    // Parser states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIELDS = 2'd1,
        CHECK  = 2'd2,
        HOLD   = 2'd3
    } parser_state_t;

    localparam logic [7:0] SIG_SYNC_DEFAULT = 8'hA5;

    // Field positions inside a frame, after the sync byte
    localparam logic [1:0] REGION = 2'd0;
    localparam logic [1:0] AUTH   = 2'd1;
    localparam logic [1:0] EXPIRY = 2'd2;
    localparam logic [1:0] SIGID  = 2'd3;

    // One decoded record; region sits in the most significant byte
    typedef struct packed {
        logic [7:0] region;
        logic [7:0] auth_level;
        logic [7:0] expiry;
        logic [7:0] signature_id;
    } sig_record_t;

endpackage

// File: rtl/sig_timeout_ctr.sv
// sig_timeout_ctr: counts idle cycles inside a frame. expired is asserted
// combinationally on the TIMEOUT_CYC-th consecutive inc cycle, so the
// owner can act on that same clock edge.
module sig_timeout_ctr #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    // Count only needs to reach TIMEOUT_CYC-1; the next inc expires
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count;

    assign expired = inc && (count == LAST);

    // Idle-cycle counter, restarts on clear or on expiry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sig_record_parser.sv
// sig_record_parser: frames a byte stream of signature records
// (SYNC, region, auth_level, expiry, signature_id, chk) with chk being the
// XOR of the four field bytes, and holds each good record under a
// valid/ready handshake.
//
// Handshakes: a byte moves when in_valid && in_ready on a rising edge; a
// record moves when rec_valid && rec_ready on a rising edge. rec_valid and
// the fields stay stable until the record moves.
//
// Optional build macro SIG_PARSER_ERR_CNT_EN adds err_count, a saturating
// count of error pulses.
module sig_record_parser
    import sig_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SIG_SYNC_DEFAULT,
    parameter int         TIMEOUT_CYC = 16
`ifdef SIG_PARSER_ERR_CNT_EN
    ,
    parameter int         ERR_CNT_W   = 8
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] region,
    output logic [7:0] auth_level,
    output logic [7:0] expiry,
    output logic [7:0] signature_id,
    output logic       rec_valid,
    input  logic       rec_ready,
    output logic       err_checksum,
    output logic       err_timeout
`ifdef SIG_PARSER_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    parser_state_t state;
    logic [1:0]    idx;
    logic [7:0]    xor_acc;
    sig_record_t   shadow;
    sig_record_t   rec;
    logic          accept;
    logic          in_frame;
    logic          expired;

    assign in_ready     = (state != HOLD);
    assign accept       = in_valid && in_ready;
    assign in_frame     = (state == FIELDS) || (state == CHECK);

    assign region       = rec.region;
    assign auth_level   = rec.auth_level;
    assign expiry       = rec.expiry;
    assign signature_id = rec.signature_id;

    // Idle counter only runs mid-frame; any accepted byte or leaving the
    // frame resets it
    sig_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_frame || accept),
        .inc    (in_frame && !accept),
        .expired(expired)
    );

    // Frame state machine with registered record and error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= REGION;
            xor_acc      <= '0;
            shadow       <= '0;
            rec          <= '0;
            rec_valid    <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    // Anything but the sync byte is line noise
                    if (accept && (in_data == SYNC_BYTE)) begin
                        state   <= FIELDS;
                        idx     <= REGION;
                        xor_acc <= '0;
                    end
                end
                FIELDS: begin
                    // A sync value here is field data, never a resync
                    if (accept) begin
                        case (idx)
                            REGION:  shadow.region       <= in_data;
                            AUTH:    shadow.auth_level   <= in_data;
                            EXPIRY:  shadow.expiry       <= in_data;
                            default: shadow.signature_id <= in_data;
                        endcase
                        xor_acc <= xor_acc ^ in_data;
                        if (idx == SIGID) begin
                            state <= CHECK;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (expired) begin
                        err_timeout <= 1'b1;
                        shadow      <= '0;
                        state       <= IDLE;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (in_data == xor_acc) begin
                            rec       <= shadow;
                            rec_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            err_checksum <= 1'b1;
                            state        <= IDLE;
                        end
                    end else if (expired) begin
                        err_timeout <= 1'b1;
                        shadow      <= '0;
                        state       <= IDLE;
                    end
                end
                HOLD: begin
                    if (rec_ready) begin
                        rec_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SIG_PARSER_ERR_CNT_EN
    // Saturating tally of error pulses, sticks at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if ((err_checksum || err_timeout) && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule
